// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count-derived status flags, sticky error flags
// and a choice of registered-read or first-word-fall-through output.
module sync_fifo_flags #(
  parameter int Dsize     = 8,
  parameter int Adsize    = 4,
  parameter int AFULL_TH  = (1 << Adsize) - 2,
  parameter int AEMPTY_TH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [Dsize-1:0]  w_data,
  input  logic              winc,
  input  logic              rinc,
  output logic [Dsize-1:0]  rd_data,
  output logic              rd_valid,
  output logic              wfull,
  output logic              rempty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [Adsize:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << Adsize;
  localparam logic [Adsize:0] FULL_C = (Adsize+1)'(DEPTH);
  localparam logic [Adsize:0] AF_C   = (Adsize+1)'(AFULL_TH);
  localparam logic [Adsize:0] AE_C   = (Adsize+1)'(AEMPTY_TH);

  logic [Dsize-1:0]  mem_q [DEPTH];
  logic [Adsize-1:0] wptr_q, wptr_d;
  logic [Adsize-1:0] rptr_q, rptr_d;
  logic [Adsize:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_en, rd_en;

  assign wfull        = (count_q == FULL_C);
  assign rempty       = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A flush cycle swallows both requests
  assign wr_en = winc & ~wfull & ~clr;
  assign rd_en = rinc & ~rempty & ~clr;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (winc & wfull);
    unf_d   = unf_q | (rinc & rempty);
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (rd_en) rptr_d = rptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is never reset; flags keep stale words unobservable
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wptr_q] <= w_data;
  end

  if (FWFT) begin : g_fwft
    assign rd_data  = rempty ? '0 : mem_q[rptr_q];
    assign rd_valid = ~rempty;
  end else begin : g_reg
    logic [Dsize-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_en;
        if (rd_en) rd_data_q <= mem_q[rptr_q];
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed and model-checked bench for sync_fifo_flags,
// registered-read and first-word-fall-through instances.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst, clr, winc, rinc;
  logic [7:0] w_data;
  logic [7:0] rd_data;
  logic       rd_valid, wfull, rempty, afull, aempty, ovf, unf;
  logic [4:0] count;

  logic       clr1, winc1, rinc1;
  logic [7:0] w_data1;
  logic [7:0] rd_data1;
  logic       rd_valid1, wfull1, rempty1, afull1, aempty1, ovf1, unf1;
  logic [4:0] count1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .Dsize(8), .Adsize(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1'b0)
  ) u0 (
    .clk(clk), .rst(rst), .clr(clr), .w_data(w_data),
    .winc(winc), .rinc(rinc), .rd_data(rd_data), .rd_valid(rd_valid),
    .wfull(wfull), .rempty(rempty), .almost_full(afull),
    .almost_empty(aempty), .count(count), .overflow(ovf),
    .underflow(unf)
  );

  sync_fifo_flags #(
    .Dsize(8), .Adsize(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1'b1)
  ) u1 (
    .clk(clk), .rst(rst), .clr(clr1), .w_data(w_data1),
    .winc(winc1), .rinc(rinc1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .wfull(wfull1), .rempty(rempty1),
    .almost_full(afull1), .almost_empty(aempty1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_count", count, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_wfull", wfull, 0);
    chk("rst_aempty", aempty, 1);
    chk("rst_afull", afull, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("rst_rdvalid", rd_valid, 0);
    chk("rst_rddata", rd_data, 0);
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic       wacc, racc;

  initial begin
    rst = 1'b1; clr = 1'b0; winc = 1'b0; rinc = 1'b0; w_data = '0;
    clr1 = 1'b0; winc1 = 1'b0; rinc1 = 1'b0; w_data1 = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset();
    chk("fw_rst_valid", rd_valid1, 0);
    chk("fw_rst_rempty", rempty1, 1);

    // FWFT instance
    winc1 = 1'b1; w_data1 = 8'h5C;
    tick();
    winc1 = 1'b0;
    chk("fw_valid", rd_valid1, 1);
    chk("fw_data", rd_data1, 8'h5C);
    rinc1 = 1'b1;
    tick();
    rinc1 = 1'b0;
    chk("fw_rempty", rempty1, 1);
    chk("fw_valid_lo", rd_valid1, 0);

    // fill to full
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; w_data = 8'(i);
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_afull", afull, (i + 1) >= 14);
      chk("fill_aempty", aempty, (i + 1) <= 2);
      chk("fill_wfull", wfull, (i + 1) == 16);
    end
    w_data = 8'hAA;
    tick();
    winc = 1'b0;
    chk("ovf_count", count, 16);
    chk("ovf_flag", ovf, 1);
    chk("ovf_wfull", wfull, 1);
    chk("ovf_novalid", rd_valid, 0);

    // drain in order
    for (int i = 0; i < 16; i++) begin
      rinc = 1'b1;
      tick();
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, i);
      chk("drain_count", count, 15 - i);
      chk("drain_aempty", aempty, (15 - i) <= 2);
    end
    rinc = 1'b0;
    tick();
    chk("drain_pulse", rd_valid, 0);
    chk("drain_hold", rd_data, 8'h0F);
    chk("drain_rempty", rempty, 1);
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    chk("unf_flag", unf, 1);
    chk("unf_count", count, 0);
    chk("unf_novalid", rd_valid, 0);
    chk("ovf_sticky", ovf, 1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("clr_unf", unf, 0);

    // simultaneous at empty
    winc = 1'b1; rinc = 1'b1; w_data = 8'h77;
    tick();
    rinc = 1'b0;
    chk("sim0_count", count, 1);
    chk("sim0_unf", unf, 1);
    chk("sim0_valid", rd_valid, 0);
    for (int i = 0; i < 4; i++) begin
      w_data = 8'h78 + 8'(i);
      tick();
    end
    chk("sim5_pre", count, 5);
    rinc = 1'b1; w_data = 8'h7C;
    tick();
    rinc = 1'b0;
    chk("sim5_count", count, 5);
    chk("sim5_valid", rd_valid, 1);
    chk("sim5_data", rd_data, 8'h77);
    for (int i = 0; i < 11; i++) begin
      w_data = 8'h80 + 8'(i);
      tick();
    end
    chk("sim16_pre", count, 16);
    rinc = 1'b1; w_data = 8'hEE;
    tick();
    winc = 1'b0; rinc = 1'b0;
    chk("sim16_count", count, 15);
    chk("sim16_ovf", ovf, 1);
    chk("sim16_data", rd_data, 8'h78);

    // down to 9 with overflow set, then flush
    rinc = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rinc = 1'b0;
    chk("pre_clr_count", count, 9);
    chk("pre_clr_ovf", ovf, 1);
    clr = 1'b1; winc = 1'b1; rinc = 1'b1; w_data = 8'hDD;
    tick();
    clr = 1'b0; winc = 1'b0; rinc = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_ovf2", ovf, 0);
    chk("clr_rempty", rempty, 1);
    chk("clr_valid", rd_valid, 0);
    winc = 1'b1; w_data = 8'h33;
    tick();
    winc = 1'b0; rinc = 1'b1;
    tick();
    rinc = 1'b0;
    chk("clr_rd_valid", rd_valid, 1);
    chk("clr_rd_data", rd_data, 8'h33);

    // rst beats clr, stored words discarded
    winc = 1'b1; w_data = 8'h99;
    tick();
    tick();
    winc = 1'b0;
    rst = 1'b1; clr = 1'b1;
    tick();
    rst = 1'b0; clr = 1'b0;
    chk_reset();
    winc = 1'b1; w_data = 8'h44;
    tick();
    winc = 1'b0; rinc = 1'b1;
    tick();
    rinc = 1'b0;
    chk("post_rst_data", rd_data, 8'h44);
    chk("post_rst_empty", rempty, 1);

    // random traffic against a queue model
    clr = 1'b1;
    tick();
    clr = 1'b0;
    q.delete();
    for (int c = 0; c < 200; c++) begin
      winc = ($urandom_range(0, 99) < ((c < 100) ? 70 : 30));
      rinc = ($urandom_range(0, 99) < ((c < 100) ? 30 : 70));
      w_data = 8'($urandom);
      wacc = winc && (q.size() < 16);
      racc = rinc && (q.size() > 0);
      exp_d = '0;
      if (racc) exp_d = q.pop_front();
      if (wacc) q.push_back(w_data);
      tick();
      chk("rnd_count", count, q.size());
      chk("rnd_valid", rd_valid, racc);
      if (racc) chk("rnd_data", rd_data, exp_d);
    end
    winc = 1'b0; rinc = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
